// File: rtl/beam_threshold_loader.sv
// beam_threshold_loader: stages per-beam thresholds and streams them to the trigger core on commit
// Ports: clk_i/rst_i (async active-high); wr_valid_i/wr_addr_i/wr_data_i stage a threshold;
// commit_i starts a load; thresh_o/thresh_ce_o/update_o feed beam_alignment; busy_o/done_o report progress.
// Optional macro DIRTY_ONLY_EN: only beams written since their last load are streamed.
module beam_threshold_loader #(
  parameter int NBEAMS = 2,
  parameter int THRESH_W = 18,
  parameter logic [THRESH_W-1:0] THRESH_INIT = 18'h3FFFF,
  localparam int AW = NBEAMS > 1 ? $clog2(NBEAMS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_valid_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [THRESH_W-1:0] wr_data_i,
  input  logic                commit_i,
  output logic [THRESH_W-1:0] thresh_o,
  output logic [NBEAMS-1:0]   thresh_ce_o,
  output logic                update_o,
  output logic                busy_o,
  output logic                done_o
);
  typedef enum logic [1:0] {IDLE, LOAD, UPDATE} state_t;
  state_t state, state_n;
  logic [AW-1:0] idx, idx_n, hit_idx;
  logic [THRESH_W-1:0] stage [NBEAMS];
  logic [NBEAMS-1:0] pend;
  logic hit, wr_ok;
  assign wr_ok = wr_valid_i && (32'(wr_addr_i) < 32'(NBEAMS));
  // highest pending beam strictly below the current one (any beam when starting from IDLE)
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NBEAMS; i++)
      if (pend[i] && (state == IDLE || i < int'(idx))) begin
        hit = 1'b1;
        hit_idx = AW'(i);
      end
  end
  always_comb begin
    state_n = state == UPDATE ? IDLE : (state == LOAD || commit_i) ? (hit ? LOAD : UPDATE) : IDLE;
    idx_n = hit ? hit_idx : idx;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      idx <= '0;
      thresh_o <= '0;
      thresh_ce_o <= '0;
      update_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      thresh_o <= state_n == LOAD ? stage[idx_n] : '0;
      thresh_ce_o <= state_n == LOAD ? NBEAMS'(1) << idx_n : '0;
      update_o <= state_n == UPDATE;
      busy_o <= state_n != IDLE;
      done_o <= state_n == UPDATE;
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int i = 0; i < NBEAMS; i++) stage[i] <= THRESH_INIT;
    end else if (wr_ok) begin
      stage[wr_addr_i] <= wr_data_i;
    end
`ifdef DIRTY_ONLY_EN
  logic [NBEAMS-1:0] dirty;
  // a write landing on the edge that loads the beam keeps it dirty for the next commit
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      dirty <= '1;
    end else begin
      for (int i = 0; i < NBEAMS; i++)
        if (wr_ok && wr_addr_i == AW'(i)) dirty[i] <= 1'b1;
        else if (state_n == LOAD && idx_n == AW'(i)) dirty[i] <= 1'b0;
    end
  assign pend = dirty;
`else
  assign pend = '1;
`endif
endmodule
